axil_master_engine: RTL and testbench

AXI4-Lite initiator that converts a simple single-command request/response interface into complete AXI4-Lite transactions on the AW, W, B, AR and R channels.
It is the initiator counterpart to the team's memory-backed AXI4-Lite responder and sits between a local controller and the bus.
It handles one transaction at a time. The address is a byte address; data is one full word.

---
 rtl/axil_master_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_axil_master_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_engine.sv
`default_nettype none
// ============================================================================
//  Module   : axil_master_engine
//  Purpose  : AXI4-Lite initiator. It turns one local command (read or write
//             of one full word at a byte address) into a complete AXI4-Lite
//             transaction, then returns one response. Only one transaction
//             is in flight at a time.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ACLK, ARESETn          clock, synchronous active-low reset
//    cmd_*                  command in (valid/ready handshake)
//    rsp_*                  response out (valid/ready handshake), held
//                           stable until rsp_ready
//    AW*/W*/B*/AR*/R*       AXI4-Lite initiator channels
//  Optional (macro AXIL_ERR_CNT_EN)
//    err_count [7:0]        saturating count of SLVERR/DECERR responses
//    err_clr   [0:0]        clears err_count; wins over a same-cycle increment
// ============================================================================
module axil_master_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // write address / data / response
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // read address / data
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
`ifdef AXIL_ERR_CNT_EN
  ,
  output logic [7:0]        err_count,
  input  logic [0:0]        err_clr
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,   // AW and/or W still pending
    WB   = 3'd2,   // awaiting B
    RA   = 3'd3,   // AR pending
    RD   = 3'd4,   // awaiting R
    RSP  = 3'd5    // response presented locally
  } state_t;

  localparam logic [ADDR_W-1:0] c_BYTE_OFS = ADDR_W'(3);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_awaddr;
  logic [ADDR_W-1:0] r_araddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_resp;

  logic              w_cmd_hs;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wr_done;
  logic              w_ar_hs;
  logic              w_b_hs;
  logic              w_r_hs;
  logic              w_rsp_hs;
  logic [ADDR_W-1:0] w_addr_aligned;

  // Transfers are whole words, so the byte offset is forced to zero.
  assign w_addr_aligned = cmd_addr & ~c_BYTE_OFS;

  assign cmd_ready = (r_state == IDLE) && ARESETn;

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_aw_hs   = r_awvalid && AWREADY;
  assign w_w_hs    = r_wvalid  && WREADY;
  // A channel counts as finished if it already completed or completes now;
  // this lets AW and W finish in any order or together.
  assign w_wr_done = (!r_awvalid || AWREADY) && (!r_wvalid || WREADY);
  assign w_ar_hs   = r_arvalid && ARREADY;
  // BREADY/RREADY are only ever high in WB/RD, so an early B or R from the
  // slave cannot be taken before its state.
  assign w_b_hs    = BVALID && r_bready;
  assign w_r_hs    = RVALID && r_rready;
  assign w_rsp_hs  = r_rsp_valid && rsp_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_cmd_hs)  w_state_nxt = cmd_write ? WR : RA;
      WR:   if (w_wr_done) w_state_nxt = WB;
      WB:   if (w_b_hs)    w_state_nxt = RSP;
      RA:   if (w_ar_hs)   w_state_nxt = RD;
      RD:   if (w_r_hs)    w_state_nxt = RSP;
      RSP:  if (w_rsp_hs)  w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered channel controls and payloads. Every VALID/READY is a flop,
  // so none depends combinationally on the far side's READY/VALID.
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      if (w_cmd_hs) begin
        if (cmd_write) begin
          r_awaddr  <= w_addr_aligned;
          r_wdata   <= cmd_wdata;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end else begin
          r_araddr  <= w_addr_aligned;
          r_arvalid <= 1'b1;
        end
      end

      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;

      if ((r_state == WR) && w_wr_done) r_bready <= 1'b1;

      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end

      if (w_b_hs) begin
        r_bready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= BRESP;
      end

      if (w_r_hs) begin
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= RDATA;
        r_rsp_resp  <= RRESP;
      end

      if (w_rsp_hs) r_rsp_valid <= 1'b0;
    end
  end

`ifdef AXIL_ERR_CNT_EN
  // SLVERR (10) and DECERR (11) both have bit 1 set.
  logic       w_err_hit;
  logic [7:0] r_err_count;

  assign w_err_hit = (w_b_hs && BRESP[1]) || (w_r_hs && RRESP[1]);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_err_count <= 8'h00;
    end else if (err_clr[0]) begin
      r_err_count <= 8'h00;
    end else if (w_err_hit && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_count = r_err_count;
`endif

  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

endmodule
`default_nettype wire

// File: tb/tb_axil_master_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_master_engine
//  Purpose  : Directed self-checking bench for axil_master_engine. The AXI
//             slave side is driven step by step from a single initial block;
//             outputs are sampled 1 time unit after each rising edge.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_axil_master_engine;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
`ifdef AXIL_ERR_CNT_EN
  logic [7:0]        err_count;
  logic [0:0]        err_clr;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  axil_master_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY)
`ifdef AXIL_ERR_CNT_EN
    ,
    .err_count (err_count),
    .err_clr   (err_clr)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
  endtask

  // Read against an always-ready slave, response consumed immediately.
  task automatic fast_read(input logic [1:0] resp, input logic [31:0] data);
    int n;
    ARREADY = 1'b1; RVALID = 1'b1; RRESP = resp; RDATA = data;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("fast_read_rsp_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    slave_idle();
  endtask

  initial begin
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    slave_idle();
`ifdef AXIL_ERR_CNT_EN
    err_clr = 1'b0;
`endif

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid",  WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready",  BREADY, 0);
    chk("rst_rready",  RREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready_in_reset", cmd_ready, 0);
`ifdef AXIL_ERR_CNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    ARESETn = 1'b1;
    #1;
    chk("cmd_ready_after_release", cmd_ready, 1);

    // ---------------- write, always-ready slave ----------------
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h04C; cmd_wdata = 32'hDEADBEEF;
    tick();                                  // cycle 1
    cmd_valid = 1'b0;
    chk("wr_c1_awvalid", AWVALID, 1);
    chk("wr_c1_wvalid",  WVALID, 1);
    chk("wr_c1_awaddr",  AWADDR, 10'h04C);
    chk("wr_c1_wdata",   WDATA, 32'hDEADBEEF);
    chk("wr_c1_bready",  BREADY, 0);
    chk("wr_c1_cmd_ready", cmd_ready, 0);
    tick();                                  // cycle 2
    chk("wr_c2_awvalid", AWVALID, 0);
    chk("wr_c2_wvalid",  WVALID, 0);
    chk("wr_c2_bready",  BREADY, 1);
    chk("wr_c2_rsp_valid", rsp_valid, 0);
    tick();                                  // cycle 3
    slave_idle();
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_resp",  rsp_resp, 2'b00);
    chk("wr_c3_rsp_write", rsp_write, 1);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_bready",    BREADY, 0);
    rsp_ready = 1'b1;
    tick();                                  // cycle 4
    rsp_ready = 1'b0;
    chk("wr_c4_rsp_valid", rsp_valid, 0);
    chk("wr_c4_cmd_ready", cmd_ready, 1);

    // ---------------- read, ARREADY delayed 3 cycles ----------------
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h07F;
    tick();                                  // cycle 1
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("rd_arvalid_held", ARVALID, 1);
      chk("rd_araddr_held",  ARADDR, 10'h07C);
      chk("rd_rready_in_ra", RREADY, 0);
      if (c == 4) ARREADY = 1'b1;
      tick();
    end
    ARREADY = 1'b0;                          // cycle 5
    chk("rd_c5_arvalid", ARVALID, 0);
    chk("rd_c5_rready",  RREADY, 1);
    RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b00;
    tick();                                  // cycle 6
    slave_idle();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_resp",  rsp_resp, 2'b00);
    chk("rd_rsp_write", rsp_write, 0);
    chk("rd_rready_drop", RREADY, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_back_idle", cmd_ready, 1);

    // ---------------- skewed write: AW at 1, W at 5 ----------------
    AWREADY = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h100; cmd_wdata = 32'hA5A50001;
    tick();                                  // cycle 1
    cmd_valid = 1'b0;
    chk("skw_c1_awvalid", AWVALID, 1);
    chk("skw_c1_wvalid",  WVALID, 1);
    tick();                                  // cycle 2
    AWREADY = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk("skw_awvalid_low", AWVALID, 0);
      chk("skw_wvalid_high", WVALID, 1);
      chk("skw_wdata_stable", WDATA, 32'hA5A50001);
      chk("skw_bready_low", BREADY, 0);
      if (c == 5) WREADY = 1'b1;
      tick();
    end
    WREADY = 1'b0;                           // cycle 6
    chk("skw_c6_wvalid", WVALID, 0);
    chk("skw_c6_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b01;
    tick();                                  // cycle 7
    slave_idle();
    chk("skw_rsp_valid", rsp_valid, 1);
    chk("skw_rsp_resp",  rsp_resp, 2'b01);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("skw_single_rsp", rsp_valid, 0);
      tick();
    end

    // ---------------- response backpressure with SLVERR ----------------
    ARREADY = 1'b1; RVALID = 1'b1; RRESP = 2'b10; RDATA = 32'hCAFEF00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h200;
    tick();                                  // cycle 1
    cmd_valid = 1'b0;
    chk("bp_c1_arvalid", ARVALID, 1);
    chk("bp_c1_rready_early_r", RREADY, 0);
    tick();                                  // cycle 2
    chk("bp_c2_rready", RREADY, 1);
    tick();                                  // cycle 3
    slave_idle();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h300;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_resp",  rsp_resp, 2'b10);
      chk("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_no_cmd_taken", AWVALID, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_done", rsp_valid, 0);
`ifdef AXIL_ERR_CNT_EN
    chk("err_count_one", err_count, 1);
`endif
    for (int i = 0; i < 299; i++) begin
      fast_read((i % 2 == 0) ? 2'b11 : 2'b10, i);
    end
`ifdef AXIL_ERR_CNT_EN
    chk("err_count_saturated", err_count, 8'hFF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_count_cleared", err_count, 0);
`endif

    // ---------------- reset mid-transaction ----------------
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h0F0; cmd_wdata = 32'h11112222;
    tick();
    cmd_valid = 1'b0;
    chk("mid_awvalid", AWVALID, 1);
    ARESETn = 1'b0;
    tick();
    chk("mid_rst_awvalid", AWVALID, 0);
    chk("mid_rst_wvalid",  WVALID, 0);
    chk("mid_rst_bready",  BREADY, 0);
    chk("mid_rst_arvalid", ARVALID, 0);
    chk("mid_rst_rready",  RREADY, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    chk("mid_rst_awaddr",  AWADDR, 0);
    ARESETn = 1'b1;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_no_bready", BREADY, 0);
    end
    slave_idle();

    // ---------------- early BVALID while AW pending ----------------
    WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b11;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h3FE; cmd_wdata = 32'h0BADF00D;
    tick();                                  // cycle 1
    cmd_valid = 1'b0;
    chk("eb_c1_awaddr", AWADDR, 10'h3FC);
    for (int c = 1; c <= 3; c++) begin
      chk("eb_bready_low", BREADY, 0);
      chk("eb_awvalid_high", AWVALID, 1);
      if (c == 3) AWREADY = 1'b1;
      tick();
    end
    AWREADY = 1'b0; WREADY = 1'b0;           // cycle 4
    chk("eb_c4_awvalid", AWVALID, 0);
    chk("eb_c4_bready", BREADY, 1);
    tick();                                  // cycle 5
    chk("eb_rsp_valid", rsp_valid, 1);
    chk("eb_rsp_resp",  rsp_resp, 2'b11);
    chk("eb_bready_drop", BREADY, 0);
    tick();                                  // still in RSP, BVALID still high
    chk("eb_single_b", BREADY, 0);
    BVALID = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("eb_done", cmd_ready, 1);
`ifdef AXIL_ERR_CNT_EN
    chk("eb_err_count", err_count, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
